// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry path: FSM states, column ring
// reset value, the key map table and small lookup helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam logic [3:0] COL_RESET = 4'b1110;

   // Key map flattened as nibble index {row, col}:
   // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
   localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

   function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
      return KEYMAP[{r, c, 2'b00} +: 4];
   endfunction

   // Lowest-index row that is pulled low; caller guarantees at least one is low
   function automatic logic [1:0] lowest_low(input logic [3:0] v);
      if (!v[0])      return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   // Index of the single active-low column in the ring
   function automatic logic [1:0] active_col(input logic [3:0] c);
      if (!c[0])      return 2'd0;
      else if (!c[1]) return 2'd1;
      else if (!c[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   // Advance the column ring: 1110 -> 1101 -> 1011 -> 0111 -> 1110
   function automatic logic [3:0] rotate_col(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Scan slot timer: free-running modulo-(TC+1) counter whose terminal count
// is the one-cycle tick that paces column scanning and debounce sampling.
module key_scan_tick #(
   parameter int TC = 199999
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (TC > 0) ? $clog2(TC + 1) : 1;
   localparam logic [W-1:0] TC_V = W'(TC);

   logic [W-1:0] count;

   // Count clocks within the slot, wrapping on the terminal count
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (count == TC_V) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tick = (count == TC_V);

endmodule

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad front end: scans columns, debounces presses and releases
// on scan ticks, emits one hex code per press and shifts it into an 8-bit
// operand. Optional macro KEY_REPEAT_EN adds auto-repeat while a key is held.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_TC    = 199999,
   parameter int DEBOUNCE_N = 4
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_N   = 250
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   input  logic       clr,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [7:0] operand
);

   localparam int CW = $clog2(DEBOUNCE_N + 1);
   localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_N);

`ifdef KEY_REPEAT_EN
   localparam int HW = (REPEAT_N > 1) ? $clog2(REPEAT_N) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_N - 1);
   logic [HW-1:0] hold;
`endif

   state_t        state;
   logic          tick;
   logic [1:0]    r;
   logic [1:0]    c;
   logic [CW-1:0] cnt;
   logic [CW-1:0] rel;
   logic [3:0]    code;

   key_scan_tick #(
      .TC (SCAN_TC)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign code = key_lookup(r, c);

   // Scan/debounce/held FSM with column ring, counters and operand register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         col       <= COL_RESET;
         key_code  <= '0;
         key_valid <= 1'b0;
         operand   <= '0;
         r         <= '0;
         c         <= '0;
         cnt       <= '0;
         rel       <= '0;
`ifdef KEY_REPEAT_EN
         hold      <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (tick) begin
            unique case (state)
               SCAN: begin
                  if (row == 4'hF) begin
                     col <= rotate_col(col);
                  end else begin
                     r     <= lowest_low(row);
                     c     <= active_col(col);
                     cnt   <= CW'(1);
                     state <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (!row[r]) begin
                     if (cnt == DB_MAX) begin
                        state     <= HELD;
                        rel       <= '0;
                        key_code  <= code;
                        key_valid <= 1'b1;
                        operand   <= {operand[3:0], code};
`ifdef KEY_REPEAT_EN
                        hold      <= '0;
`endif
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end else begin
                     state <= SCAN;
                     col   <= rotate_col(col);
                  end
               end
               HELD: begin
                  if (row[r]) begin
`ifdef KEY_REPEAT_EN
                     hold <= '0;
`endif
                     if (rel == DB_MAX) begin
                        state <= SCAN;
                        col   <= rotate_col(col);
                        rel   <= '0;
                     end else begin
                        rel <= rel + CW'(1);
                     end
                  end else begin
                     rel <= '0;
`ifdef KEY_REPEAT_EN
                     if (hold == HOLD_LAST) begin
                        hold      <= '0;
                        key_code  <= code;
                        key_valid <= 1'b1;
                        operand   <= {operand[3:0], code};
                     end else begin
                        hold <= hold + HW'(1);
                     end
`endif
                  end
               end
               default: begin
                  state <= SCAN;
               end
            endcase
         end
         if (clr) begin
            operand <= '0;
         end
      end
   end

endmodule
